// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with flush and ctrl bit-mask.
// Latency: 1 cycle from accept to out_valid when empty; bubbles never raise wb/mem write enables.
// Backpressure: out_ready=0 holds the outputs stable. Default build is a single entry with
//   in_ready = !out_valid | out_ready. Define PIPE_REG_SKID_EN for a two-entry skid buffer
//   (main + skid) whose in_ready is registered and has no combinational path from out_ready.
module pipe_stage_reg #(
  parameter int                DATA_W    = 160,
  parameter int                CTRL_W    = 15,
  parameter logic [CTRL_W-1:0] CTRL_MASK = 15'h40FD,
  parameter int                ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_regw_addr,
  input  logic              in_wb_wen,
  input  logic              in_mem_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_regw_addr,
  output logic              out_wb_wen,
  output logic              out_mem_wen
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] addr;
    logic              wb_wen;
    logic              mem_wen;
  } entry_t;

  entry_t in_ent;
  entry_t main_q;
  logic   accept;
  logic   drain;

  // Masking happens here, at capture, so a held entry never carries unmasked ctrl bits.
  assign in_ent.data    = in_data;
  assign in_ent.ctrl    = in_ctrl & CTRL_MASK;
  assign in_ent.addr    = in_regw_addr;
  assign in_ent.wb_wen  = in_wb_wen;
  assign in_ent.mem_wen = in_mem_wen;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Payload fields hold their last value through bubbles; only the enables are gated.
  assign out_data      = main_q.data;
  assign out_ctrl      = main_q.ctrl;
  assign out_regw_addr = main_q.addr;
  assign out_wb_wen    = main_q.wb_wen & out_valid;
  assign out_mem_wen   = main_q.mem_wen & out_valid;

`ifdef PIPE_REG_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q;
  entry_t skid_q;
  logic   in_ready_q;
  logic   out_valid_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  // Occupancy FSM: main always feeds the outputs, skid absorbs the entry that arrives during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q      <= in_ent;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_q     <= in_ent;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (drain && !accept) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (accept && drain) begin
            main_q <= in_ent;
          end
        end
        TWO: begin
          if (drain) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`else

  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q | out_ready;

  // Single entry: capture on accept (reloading in the drain cycle), empty on drain or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      main_q  <= in_ent;
    end else if (drain) begin
      valid_q <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random and directed stimulus for pipe_stage_reg against a queue model.
// Model: FIFO of accepted entries, capacity 1 (default) or 2 (PIPE_REG_SKID_EN).
// Build with PIPE_REG_SKID_EN defined to exercise the skid-buffer variant.
module tb_pipe_stage_reg;
  localparam int DATA_W = 160;
  localparam int CTRL_W = 15;
  localparam int ADDR_W = 5;
  localparam logic [CTRL_W-1:0] MASK = 15'h40FD;
`ifdef PIPE_REG_SKID_EN
  localparam int FILL = 2;
`else
  localparam int FILL = 1;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] addr;
    logic              wb;
    logic              mem;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, in_wb_wen, in_mem_wen;
  logic              out_valid, out_ready, out_wb_wen, out_mem_wen;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [ADDR_W-1:0] in_regw_addr, out_regw_addr;

  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;
  ent_t mq[$];
  ent_t shown = '0;
  logic [15:0] drain_log[$];

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .in_regw_addr(in_regw_addr), .in_wb_wen(in_wb_wen), .in_mem_wen(in_mem_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .out_regw_addr(out_regw_addr), .out_wb_wen(out_wb_wen), .out_mem_wen(out_mem_wen)
  );

  always #5 clk = ~clk;

  // Readiness from occupancy alone: room in the buffer, or (single entry) a same-cycle drain.
  function automatic bit exp_rdy(int n, logic ordy);
`ifdef PIPE_REG_SKID_EN
    return n < 2;
`else
    return (n == 0) || (ordy === 1'b1);
`endif
  endfunction

  task automatic check(string nm, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model update at every edge: reset/flush empty the FIFO, otherwise pop on drain and push on accept.
  always @(posedge clk) begin
    int n;
    bit rdy;
    ent_t e;
    n = mq.size();
    rdy = exp_rdy(n, out_ready);
    if (rst) begin
      mq.delete();
      shown = '0;
      chk_en = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (n > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && rdy) begin
        e.data = in_data;
        e.ctrl = in_ctrl & MASK;
        e.addr = in_regw_addr;
        e.wb   = in_wb_wen;
        e.mem  = in_mem_wen;
        mq.push_back(e);
      end
      if (mq.size() > 0) shown = mq[0];
    end
  end

  // Compare process: every cycle once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq.size() > 0);
      check("in_ready", in_ready, exp_rdy(mq.size(), out_ready));
      check("out_data", out_data, shown.data);
      check("out_ctrl", out_ctrl, shown.ctrl);
      check("out_regw_addr", out_regw_addr, shown.addr);
      check("out_wb_wen", out_wb_wen, (mq.size() > 0) && shown.wb);
      check("out_mem_wen", out_mem_wen, (mq.size() > 0) && shown.mem);
      if (out_valid && out_ready) drain_log.push_back(out_data[15:0]);
    end
  end

  task automatic set_in(bit v, bit r, bit fl, bit rs, logic [DATA_W-1:0] d,
                        logic [CTRL_W-1:0] c, logic [ADDR_W-1:0] a, bit wb, bit mem);
    in_valid = v; out_ready = r; flush = fl; rst = rs;
    in_data = d; in_ctrl = c; in_regw_addr = a; in_wb_wen = wb; in_mem_wen = mem;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    bit acc;
    set_in(0, 1, 0, 1, '0, '0, '0, 0, 0);
    tick();
    tick();

    // First entry after reset, all ctrl bits set
    set_in(1, 1, 0, 0, 160'hABCD, 15'h7FFF, 5'd5, 1, 0);
    tick();
    set_in(0, 1, 0, 0, '0, '0, '0, 0, 0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_wb_wen", out_wb_wen, 1'b1);
    check("t1_mem_wen", out_mem_wen, 1'b0);
    check("t1_addr", out_regw_addr, 5'd5);
    check("t1_data", out_data, 160'hABCD);
    check("t2_ctrl_mask", out_ctrl, 15'h40FD);
    tick();
    check("t1_bubble_valid", out_valid, 1'b0);
    check("t1_bubble_wb", out_wb_wen, 1'b0);
    check("t1_bubble_hold", out_data, 160'hABCD);

    // Stream 4 entries with a stall on the 2nd cycle
    drain_log.delete();
    idx = 0;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      set_in(1, cyc != 1, 0, 0, 160'h100 + idx, 15'h0FFF, 5'(idx), 1, 0);
      #1;
      if (cyc == 1) begin
`ifdef PIPE_REG_SKID_EN
        check("t3_rdy_in_stall", in_ready, 1'b1);
`else
        check("t3_rdy_in_stall", in_ready, 1'b0);
`endif
      end
      acc = in_ready;
      tick();
      if (acc) idx++;
    end
    set_in(0, 1, 0, 0, '0, '0, '0, 0, 0);
    repeat (4) tick();
    check("t3_count", drain_log.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < drain_log.size()) check("t3_order", drain_log[k], 16'h100 + 16'(k));

    // Flush a full stage together with an incoming entry
    drain_log.delete();
    for (int k = 0; k < FILL; k++) begin
      set_in(1, 0, 0, 0, 160'h200 + k, 15'h1, 5'd7, 1, 1);
      tick();
    end
    set_in(1, 0, 1, 0, 160'hDEAD, 15'h2, 5'd9, 1, 1);
    tick();
    set_in(0, 1, 0, 0, '0, '0, '0, 0, 0);
    check("t4_valid", out_valid, 1'b0);
    check("t4_wb_wen", out_wb_wen, 1'b0);
    check("t4_mem_wen", out_mem_wen, 1'b0);
    repeat (3) tick();
    check("t4_no_drain", drain_log.size(), 0);

    // Reset while full
    for (int k = 0; k < FILL; k++) begin
      set_in(1, 0, 0, 0, 160'h300 + k, 15'h7FFF, 5'd11, 1, 1);
      tick();
    end
    set_in(0, 0, 0, 1, '0, '0, '0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, '0, '0, '0, 0, 0);
    #1;
    check("t5_valid", out_valid, 1'b0);
    check("t5_data", out_data, '0);
    check("t5_ctrl", out_ctrl, '0);
    check("t5_addr", out_regw_addr, '0);
    check("t5_wens", {out_wb_wen, out_mem_wen}, 2'b00);
    check("t5_in_ready", in_ready, 1'b1);
    set_in(1, 0, 0, 0, 160'h5A5A, 15'h0, 5'd3, 1, 0);
    tick();
    set_in(0, 1, 0, 0, '0, '0, '0, 0, 0);
    check("t5_new_valid", out_valid, 1'b1);
    check("t5_new_data", out_data, 160'h5A5A);
    tick();
    tick();

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0,
             {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
             CTRL_W'($urandom()), ADDR_W'($urandom()), 1'($urandom()), 1'($urandom()));
      tick();
    end
    set_in(0, 1, 0, 0, '0, '0, '0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
